mac_outer_acc: RTL and testbench

- Downstream stage of the W/X memory bank. Each accumulate cycle it takes one W column (w_in1..3) and one X row (x_in1..3) and adds their 3x3 outer product into nine accumulators, so C += W[:,k]*X[k,:].
- When the bank raises unload_res, it streams the row_w x col_x result matrix out serially in row-major order, using a valid/ready handshake toward the result sink.

---
 rtl/mac_outer_acc_pkg.sv | 25 ++
 rtl/mac_outer_acc_cell.sv | 36 +++
 rtl/mac_outer_acc.sv | 194 +++++++++++++++++++
 tb/tb_mac_outer_acc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_outer_acc_pkg.sv
// Shared sizes, state encoding and index helper for the outer-product accumulator.
package mac_outer_acc_pkg;

    localparam int N      = 3;
    localparam int DATA_W = 4;
    localparam int ACC_W  = 2 * DATA_W + 2;
    localparam int IDX_W  = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ACC_W-1:0]  acc_t;
    typedef logic [IDX_W-1:0]  idx_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Row-major position of element (i,j) in a matrix that is col wide.
    function automatic idx_t row_major_idx(input logic [1:0] i,
                                           input logic [1:0] j,
                                           input logic [1:0] col);
        return ({2'b00, i} * {2'b00, col}) + {2'b00, j};
    endfunction

endpackage

// File: rtl/mac_outer_acc_cell.sv
// One accumulator of the outer-product array: clears and/or adds a*b each cycle.
module mac_cell
    import mac_outer_acc_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  data_t a_i,
    input  data_t b_i,
    input  logic  en_i,
    input  logic  clr_i,
    output acc_t  acc_o
);

    logic [2*DATA_W-1:0] prod;
    acc_t                acc_q;
    acc_t                acc_d;

    assign prod = a_i * b_i;

    // Clear and accumulate may coincide: the first column lands on a cleared cell.
    always_comb begin
        acc_d = (clr_i ? '0 : acc_q)
              + (en_i ? {{(ACC_W - 2*DATA_W){1'b0}}, prod} : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mac_outer_acc.sv
// Accumulates C += W[:,k]*X[k,:] over a 3x3 cell array, then streams C out
// row-major over a valid/ready handshake.
module mac_outer_acc
    import mac_outer_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DATA_W-1:0] w_in1,
    input  logic [DATA_W-1:0] w_in2,
    input  logic [DATA_W-1:0] w_in3,
    input  logic [DATA_W-1:0] x_in1,
    input  logic [DATA_W-1:0] x_in2,
    input  logic [DATA_W-1:0] x_in3,
    input  logic             ld_mac,
    input  logic             clear_mac,
    input  logic             unload_res,
    input  logic [1:0]       row_w,
    input  logic [1:0]       col_x,
    output logic [ACC_W-1:0] res_data,
    output logic [IDX_W-1:0] res_idx,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_last,
    output logic             busy,
    output logic             done
);

    logic [1:0] state_q, state_d;
    logic [1:0] rows_q, rows_d;
    logic [1:0] cols_q, cols_d;
    logic [1:0] i_q, i_d;
    logic [1:0] j_q, j_d;
    acc_t       data_q, data_d;
    idx_t       idx_q, idx_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;

    logic       acc_en;
    logic       cell_en;
    logic       cell_clr;
    logic       fire;
    logic       load_elem;
    logic [1:0] ni, nj;

    data_t w_vec [N];
    data_t x_vec [N];
    acc_t  acc   [N][N];

    assign w_vec[0] = w_in1;
    assign w_vec[1] = w_in2;
    assign w_vec[2] = w_in3;
    assign x_vec[0] = x_in1;
    assign x_vec[1] = x_in2;
    assign x_vec[2] = x_in3;

    assign acc_en   = ld_mac & ~unload_res & ~clear_mac;
    assign cell_en  = acc_en & ((state_q == ST_IDLE) | (state_q == ST_ACCUM));
    assign cell_clr = clear_mac | (state_q == ST_IDLE);
    assign fire     = valid_q & res_ready;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                mac_cell u_cell (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .a_i   (w_vec[gi]),
                    .b_i   (x_vec[gj]),
                    .en_i  (cell_en),
                    .clr_i (cell_clr),
                    .acc_o (acc[gi][gj])
                );
            end
        end
    endgenerate

    // clear_mac wins over every state; loading an element registers the drain mux output.
    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        i_d       = i_q;
        j_d       = j_q;
        data_d    = data_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        last_d    = last_q;
        ni        = i_q;
        nj        = j_q;
        load_elem = 1'b0;

        if (clear_mac) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc_en) begin
                        state_d = ST_ACCUM;
                        rows_d  = row_w;
                        cols_d  = col_x;
                    end
                end
                ST_ACCUM: begin
                    if (unload_res) begin
                        if ((rows_q == 2'd0) || (cols_q == 2'd0)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d   = ST_DRAIN;
                            ni        = 2'd0;
                            nj        = 2'd0;
                            load_elem = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fire) begin
                        if (last_q) begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end else begin
                            load_elem = 1'b1;
                            if (j_q == cols_q - 2'd1) begin
                                ni = i_q + 2'd1;
                                nj = 2'd0;
                            end else begin
                                nj = j_q + 2'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (load_elem) begin
            i_d     = ni;
            j_d     = nj;
            valid_d = 1'b1;
            idx_d   = row_major_idx(ni, nj, cols_q);
            last_d  = (ni == rows_q - 2'd1) && (nj == cols_q - 2'd1);
            data_d  = '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if ((ni == 2'(r)) && (nj == 2'(c))) begin
                        data_d = acc[r][c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            i_q     <= i_d;
            j_q     <= j_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign res_data  = data_q;
    assign res_idx   = idx_q;
    assign res_valid = valid_q;
    assign res_last  = last_q;
    assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_mac_outer_acc.sv
// Randomized bench for mac_outer_acc against an arithmetic matrix-product model.
module tb_mac_outer_acc;
    import mac_outer_acc_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DATA_W-1:0] w_in1, w_in2, w_in3, x_in1, x_in2, x_in3;
    logic             ld_mac, clear_mac, unload_res, res_ready;
    logic [1:0]       row_w, col_x;
    logic [ACC_W-1:0] res_data;
    logic [IDX_W-1:0] res_idx;
    logic             res_valid, res_last, busy, done;

    int checks   = 0;
    int failures = 0;
    int opW [8][3];
    int opX [8][3];
    int modelAcc [3][3];
    int expIdx[$];
    int expData[$];

    always #5 clk = ~clk;

    mac_outer_acc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_in1      (w_in1),
        .w_in2      (w_in2),
        .w_in3      (w_in3),
        .x_in1      (x_in1),
        .x_in2      (x_in2),
        .x_in3      (x_in3),
        .ld_mac     (ld_mac),
        .clear_mac  (clear_mac),
        .unload_res (unload_res),
        .row_w      (row_w),
        .col_x      (col_x),
        .res_data   (res_data),
        .res_idx    (res_idx),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_last   (res_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int k, input logic ld, input logic unl,
                                 input logic clr, input logic rdy);
        w_in1      = 4'(opW[k][0]);
        w_in2      = 4'(opW[k][1]);
        w_in3      = 4'(opW[k][2]);
        x_in1      = 4'(opX[k][0]);
        x_in2      = 4'(opX[k][1]);
        x_in3      = 4'(opX[k][2]);
        ld_mac     = ld;
        unload_res = unl;
        clear_mac  = clr;
        res_ready  = rdy;
    endtask

    task automatic fillRandom(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            for (int i = 0; i < 3; i++) begin
                opW[k][i] = int'($urandom_range(0, 15));
                opX[k][i] = int'($urandom_range(0, 15));
            end
        end
    endtask

    // Full run: accumulate, unload, drain with optional stall or abort, then leave DONE.
    task automatic runMatrix(input int rows, input int cols, input int cycles,
                             input int bpIdx, input int bpLen, input int abortIdx,
                             input bit randReady);
        int  n;
        int  holds;
        int  budget;
        logic rdy;

        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                modelAcc[i][j] = 0;
        for (int k = 0; k < cycles; k++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    modelAcc[i][j] = (modelAcc[i][j] + opW[k][i] * opX[k][j]) % 1024;
        expIdx.delete();
        expData.delete();
        for (int i = 0; i < rows; i++)
            for (int j = 0; j < cols; j++) begin
                expIdx.push_back(i * cols + j);
                expData.push_back(modelAcc[i][j]);
            end

        row_w = 2'(rows);
        col_x = 2'(cols);
        for (int k = 0; k < cycles; k++) begin
            applyStimulus(k, 1'b1, 1'b0, 1'b0, 1'b1);
            tick();
            if (k == 0) begin
                row_w = 2'($urandom);
                col_x = 2'($urandom);
                checkOutput("busy_accum", int'(busy), 1);
            end
        end
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();

        n      = 0;
        holds  = bpLen;
        budget = 0;
        while (n < expIdx.size() && budget < 200) begin
            budget++;
            checkOutput("res_valid", int'(res_valid), 1);
            checkOutput("res_idx", int'(res_idx), expIdx[n]);
            checkOutput("res_data", int'(res_data), expData[n]);
            checkOutput("res_last", int'(res_last), (n == expIdx.size() - 1) ? 1 : 0);
            if (expIdx[n] == abortIdx) begin
                applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b1);
                tick();
                applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
                checkOutput("abort_valid", int'(res_valid), 0);
                checkOutput("abort_busy", int'(busy), 0);
                checkOutput("abort_done", int'(done), 0);
                return;
            end
            rdy = 1'b1;
            if (expIdx[n] == bpIdx && holds > 0) begin
                rdy = 1'b0;
                holds--;
            end else if (randReady) begin
                rdy = 1'($urandom_range(0, 1));
            end
            res_ready = rdy;
            tick();
            if (rdy) n++;
        end
        if (n < expIdx.size()) checkOutput("drain_timeout", n, expIdx.size());

        checkOutput("done", int'(done), 1);
        checkOutput("done_valid", int'(res_valid), 0);
        checkOutput("done_busy", int'(busy), 0);
        res_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checkOutput("done_hold", int'(done), 1);
            checkOutput("no_redrain", int'(res_valid), 0);
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("exit_done", int'(done), 0);
        checkOutput("exit_busy", int'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        fillRandom(8);
        rst_n = 1'b0;
        row_w = 2'd0;
        col_x = 2'd0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("rst_valid", int'(res_valid), 0);
        checkOutput("rst_last", int'(res_last), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_data", int'(res_data), 0);
        checkOutput("rst_idx", int'(res_idx), 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] 2x2 identity case");
        opW[0] = '{1, 3, 0}; opX[0] = '{1, 0, 0};
        opW[1] = '{2, 4, 0}; opX[1] = '{0, 1, 0};
        runMatrix(2, 2, 2, -1, 0, -1, 1'b0);

        $display("[TB] maximum operands with backpressure at idx 2");
        for (int k = 0; k < 3; k++) begin
            opW[k] = '{15, 15, 15};
            opX[k] = '{15, 15, 15};
        end
        runMatrix(3, 3, 3, 2, 3, -1, 1'b0);

        $display("[TB] abort at idx 4");
        fillRandom(4);
        runMatrix(3, 3, 4, -1, 0, 4, 1'b0);
        opW[0] = '{5, 0, 0}; opX[0] = '{7, 0, 0};
        runMatrix(1, 1, 1, -1, 0, -1, 1'b0);

        $display("[TB] reset during accumulate");
        fillRandom(1);
        row_w = 2'd3;
        col_x = 2'd3;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_done", int'(done), 0);
        checkOutput("mid_rst_valid", int'(res_valid), 0);
        checkOutput("mid_rst_data", int'(res_data), 0);
        checkOutput("mid_rst_idx", int'(res_idx), 0);
        rst_n = 1'b1;
        tick();
        opW[0] = '{2, 9, 9}; opX[0] = '{3, 9, 9};
        runMatrix(1, 1, 1, -1, 0, -1, 1'b0);

        $display("[TB] degenerate row_w=0");
        fillRandom(2);
        runMatrix(0, 2, 2, -1, 0, -1, 1'b0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 12; r++) begin
            int cyc;
            cyc = int'($urandom_range(1, 8));
            fillRandom(cyc);
            runMatrix(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), cyc,
                      -1, 0, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
